// File: rtl/mq_datapath.sv
// M/Q operand datapath: operand registers, gated status flag pairs and |M-Q| capture.
// Optional sticky reload-in-terminal-state error output enabled by `define MQ_LOAD_ERR_EN.
module mq_datapath #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ldM,
  input  logic             ldQ,
  input  logic             done,
  output logic             eqz1,
  output logic             neqz1,
  output logic             eqz2,
  output logic             neqz2,
  output logic             yes1,
  output logic             no1,
  output logic             yes2,
  output logic             no2,
  output logic             flags_vld,
`ifdef MQ_LOAD_ERR_EN
  output logic             err,
`endif
  output logic [WIDTH-1:0] result,
  output logic             result_vld
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_eqz1;
  logic             r_eqz2;
  logic             r_ge;
  logic             r_eq;
  logic [WIDTH-1:0] r_result;
  logic             r_result_vld;
  logic             r_done_d;

  logic             w_ld;
  logic             w_done_rise;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_abs;
  logic             w_flags_vld;

  assign w_ld        = ldM | ldQ;
  assign w_done_rise = done & ~r_done_d;
  assign w_diff      = {1'b0, r_m} - {1'b0, r_q};
  assign w_abs       = w_diff[WIDTH] ? (r_q - r_m) : w_diff[WIDTH-1:0];
  assign w_flags_vld = (r_cnt == SETTLE_C);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the simultaneous load+capture case relies on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m          <= '0;
      r_q          <= '0;
      r_cnt        <= '0;
      r_eqz1       <= 1'b0;
      r_eqz2       <= 1'b0;
      r_ge         <= 1'b0;
      r_eq         <= 1'b0;
      r_result     <= '0;
      r_result_vld <= 1'b0;
      r_done_d     <= 1'b0;
    end else begin
      if (ldM) r_m <= data_in;
      if (ldQ) r_q <= data_in;

      if (w_ld)                   r_cnt <= '0;
      else if (r_cnt < SETTLE_C)  r_cnt <= r_cnt + CW'(1);

      r_eqz1 <= (r_m == '0);
      r_eqz2 <= (r_q == '0);
      r_ge   <= ~w_diff[WIDTH];
      r_eq   <= (r_m == r_q);

      r_done_d <= done;
      // A capture wins over a load-triggered clear on the same edge.
      if (w_done_rise) begin
        r_result     <= w_abs;
        r_result_vld <= 1'b1;
      end else if (w_ld) begin
        r_result_vld <= 1'b0;
      end
    end
  end

`ifdef MQ_LOAD_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst)                              r_err <= 1'b0;
    else if (w_ld && r_result_vld && done) r_err <= 1'b1;
  end
  assign err = r_err;
`endif

  // Both members of a pair read 0 until the operands have settled.
  assign eqz1  =  r_eqz1 & w_flags_vld;
  assign neqz1 = ~r_eqz1 & w_flags_vld;
  assign eqz2  =  r_eqz2 & w_flags_vld;
  assign neqz2 = ~r_eqz2 & w_flags_vld;
  assign yes1  =  r_ge   & w_flags_vld;
  assign no1   = ~r_ge   & w_flags_vld;
  assign yes2  =  r_eq   & w_flags_vld;
  assign no2   = ~r_eq   & w_flags_vld;

  assign flags_vld  = w_flags_vld;
  assign result     = r_result;
  assign result_vld = r_result_vld;

endmodule

// File: tb/tb_mq_datapath.sv
// Self-checking bench for mq_datapath: flag settling, |M-Q| capture via a scoreboard queue.
// Build with +define+MQ_LOAD_ERR_EN to also exercise the sticky err output.
module tb_mq_datapath;

  localparam int WIDTH  = 16;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             ldM, ldQ, done;
  logic             eqz1, neqz1, eqz2, neqz2, yes1, no1, yes2, no2, flags_vld;
  logic [WIDTH-1:0] result;
  logic             result_vld;
`ifdef MQ_LOAD_ERR_EN
  logic             err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] mdl_m, mdl_q;
  logic [WIDTH-1:0] sb_q[$];

  always #5 clk = ~clk;

  mq_datapath #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .ldM       (ldM),
    .ldQ       (ldQ),
    .done      (done),
    .eqz1      (eqz1),
    .neqz1     (neqz1),
    .eqz2      (eqz2),
    .neqz2     (neqz2),
    .yes1      (yes1),
    .no1       (no1),
    .yes2      (yes2),
    .no2       (no2),
    .flags_vld (flags_vld),
`ifdef MQ_LOAD_ERR_EN
    .err       (err),
`endif
    .result    (result),
    .result_vld(result_vld)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // valid=0 expects every flag low; otherwise flags from the model operands.
  task automatic check_flags(input string tag, input bit valid);
    check({tag, ".flags_vld"}, flags_vld, valid);
    check({tag, ".eqz1"},  eqz1,  valid && (mdl_m == 0));
    check({tag, ".neqz1"}, neqz1, valid && (mdl_m != 0));
    check({tag, ".eqz2"},  eqz2,  valid && (mdl_q == 0));
    check({tag, ".neqz2"}, neqz2, valid && (mdl_q != 0));
    check({tag, ".yes1"},  yes1,  valid && (mdl_m >= mdl_q));
    check({tag, ".no1"},   no1,   valid && (mdl_m <  mdl_q));
    check({tag, ".yes2"},  yes2,  valid && (mdl_m == mdl_q));
    check({tag, ".no2"},   no2,   valid && (mdl_m != mdl_q));
  endtask

  task automatic load(input bit lm, input bit lq, input logic [WIDTH-1:0] val);
    ldM = lm; ldQ = lq; data_in = val;
    tick();
    ldM = 1'b0; ldQ = 1'b0;
    if (lm) mdl_m = val;
    if (lq) mdl_q = val;
  endtask

  // Called right after the last load edge: flags stay low until SETTLE more edges.
  task automatic settle(input string tag);
    check_flags({tag, ".s0"}, 1'b0);
    for (int i = 1; i <= SETTLE; i++) begin
      tick();
      check_flags($sformatf("%s.s%0d", tag, i), i == SETTLE);
    end
  endtask

  task automatic capture_check(input string tag);
    logic [WIDTH-1:0] exp;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_underflow"}, 1, 0);
    end else begin
      exp = sb_q.pop_front();
      check({tag, ".result"}, result, exp);
      check({tag, ".result_vld"}, result_vld, 1);
    end
  endtask

  task automatic capture(input string tag);
    done = 1'b1;
    sb_q.push_back(abs_diff(mdl_m, mdl_q));
    tick();
    capture_check(tag);
  endtask

  initial begin
    rst = 1'b1; ldM = 1'b0; ldQ = 1'b0; done = 1'b0; data_in = '0;
    mdl_m = '0; mdl_q = '0;
    tick(); tick();
    rst = 1'b0;
    check_flags("reset", 1'b0);
    check("reset.result", result, 0);
    check("reset.result_vld", result_vld, 0);
`ifdef MQ_LOAD_ERR_EN
    check("reset.err", err, 0);
`endif

    // 1: M=0, Q=5
    load(1, 0, 0);
    load(0, 1, 5);
    settle("t1");

    // 2: M=9, Q=4
    load(1, 0, 9);
    load(0, 1, 4);
    settle("t2");
    capture("t2.cap");
    done = 1'b0;
    tick();

    // 3: M=4, Q=9; done held high must not recapture
    load(1, 0, 4);
    check("t3.vld_clr", result_vld, 0);
    load(0, 1, 9);
    settle("t3");
    capture("t3.cap");
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3.hold%0d.result", i), result, 5);
      check($sformatf("t3.hold%0d.vld", i), result_vld, 1);
    end
    load(1, 0, 20);
    check("t3.reload.vld", result_vld, 0);
    check("t3.reload.result", result, 5);
`ifdef MQ_LOAD_ERR_EN
    check("t3.err_set", err, 1);
    tick();
    check("t3.err_sticky", err, 1);
`endif
    done = 1'b0;
    tick();

    // 4: both loads on the same edge
    load(1, 1, 7);
    settle("t4");
    capture("t4.cap");
    done = 1'b0;
    tick();

    // 5: reload mid-settle restarts the count
    load(1, 0, 3);
    tick();
    check_flags("t5.cnt1", 1'b0);
    load(0, 1, 6);
    settle("t5");
    // simultaneous load and done rise captures pre-load operands
    done = 1'b1; ldM = 1'b1; data_in = 100;
    sb_q.push_back(abs_diff(mdl_m, mdl_q));
    tick();
    ldM = 1'b0; mdl_m = 100;
    capture_check("t5.ldcap");
    check_flags("t5.ldcap", 1'b0);
    done = 1'b0;
    tick();

    // 6: reset mid-settle, ld/done ignored on that edge
    load(1, 0, 3);
    tick();
    rst = 1'b1; ldQ = 1'b1; done = 1'b1; data_in = 11;
    tick();
    rst = 1'b0; ldQ = 1'b0; done = 1'b0;
    mdl_m = '0; mdl_q = '0;
    check_flags("t6", 1'b0);
    check("t6.result", result, 0);
    check("t6.result_vld", result_vld, 0);
`ifdef MQ_LOAD_ERR_EN
    check("t6.err", err, 0);
`endif
    // registers really cleared: Q must read 0 after settling
    for (int i = 0; i < SETTLE + 1; i++) tick();
    check_flags("t6.post", 1'b1);

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
